// File: rtl/phv_stage_buffer_if.sv
// PHV/VLAN handshake bundle between upstream, the stage buffer and the match-action stage.
// slave is the buffer's view; master is the view of whatever surrounds it.
interface phv_stage_buffer_if #(
    parameter int PHV_LEN        = 1024,
    parameter int C_VLANID_WIDTH = 12
);
    logic [PHV_LEN-1:0]        phv_in;
    logic                      phv_in_valid;
    logic                      stage_ready_out;
    logic [C_VLANID_WIDTH-1:0] vlan_in;
    logic                      vlan_valid_in;
    logic                      vlan_ready_out;
    logic [PHV_LEN-1:0]        phv_out;
    logic                      phv_out_valid;
    logic                      stage_ready_in;
    logic [C_VLANID_WIDTH-1:0] vlan_out;
    logic                      vlan_out_valid;
    logic                      vlan_ready_in;

    modport slave (
        input  phv_in,
        input  phv_in_valid,
        output stage_ready_out,
        input  vlan_in,
        input  vlan_valid_in,
        output vlan_ready_out,
        output phv_out,
        output phv_out_valid,
        input  stage_ready_in,
        output vlan_out,
        output vlan_out_valid,
        input  vlan_ready_in
    );

    modport master (
        output phv_in,
        output phv_in_valid,
        input  stage_ready_out,
        output vlan_in,
        output vlan_valid_in,
        input  vlan_ready_out,
        input  phv_out,
        input  phv_out_valid,
        output stage_ready_in,
        input  vlan_out,
        input  vlan_out_valid,
        output vlan_ready_in
    );
endinterface

// File: rtl/phv_stage_buffer.sv
// Elastic buffer ahead of a match-action stage: issues each VLAN ID one cycle before its PHV
// so the stage can prefetch tenant config; also registers the control AXIS by one cycle.
module phv_stage_buffer #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int PHV_LEN              = 1024,
    parameter int C_VLANID_WIDTH       = 12,
    parameter int DEPTH_BITS           = 3,
    parameter int SLACK                = 2
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    phv_stage_buffer_if.slave                 pipe,
    output logic [15:0]                       phv_drop_cnt,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_LEVEL  = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] READY_LEVEL = (DEPTH_BITS+1)'(DEPTH - SLACK);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_SEND_PHV = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [PHV_LEN-1:0]        phv_mem  [DEPTH];
    logic [C_VLANID_WIDTH-1:0] vlan_mem [DEPTH];

    logic [DEPTH_BITS-1:0] phv_wr_ptr_q,  phv_wr_ptr_d;
    logic [DEPTH_BITS-1:0] phv_rd_ptr_q,  phv_rd_ptr_d;
    logic [DEPTH_BITS:0]   phv_count_q,   phv_count_d;
    logic [DEPTH_BITS-1:0] vlan_wr_ptr_q, vlan_wr_ptr_d;
    logic [DEPTH_BITS-1:0] vlan_rd_ptr_q, vlan_rd_ptr_d;
    logic [DEPTH_BITS:0]   vlan_count_q,  vlan_count_d;
    logic [15:0]           drop_cnt_q,    drop_cnt_d;

    state_t state_q, state_d;

    logic phv_push, phv_pop, phv_drop;
    logic vlan_push, vlan_pop;

    logic [PHV_LEN-1:0]        phv_out_q;
    logic                      phv_out_valid_q;
    logic [C_VLANID_WIDTH-1:0] vlan_out_q;
    logic                      vlan_out_valid_q;

    // Fullness comes from the registered count, so a same-cycle pop cannot rescue a write.
    assign phv_push  = pipe.phv_in_valid  && (phv_count_q  != FULL_LEVEL);
    assign phv_drop  = pipe.phv_in_valid  && (phv_count_q  == FULL_LEVEL);
    assign vlan_push = pipe.vlan_valid_in && (vlan_count_q != FULL_LEVEL);

    assign pipe.stage_ready_out = (phv_count_q  < READY_LEVEL);
    assign pipe.vlan_ready_out  = (vlan_count_q < READY_LEVEL);

    always_ff @(posedge axis_clk) begin
        if (phv_push) begin
            phv_mem[phv_wr_ptr_q] <= pipe.phv_in;
        end
        if (vlan_push) begin
            vlan_mem[vlan_wr_ptr_q] <= pipe.vlan_in;
        end
    end

    always_comb begin
        phv_wr_ptr_d  = phv_wr_ptr_q;
        phv_rd_ptr_d  = phv_rd_ptr_q;
        phv_count_d   = phv_count_q;
        vlan_wr_ptr_d = vlan_wr_ptr_q;
        vlan_rd_ptr_d = vlan_rd_ptr_q;
        vlan_count_d  = vlan_count_q;
        drop_cnt_d    = drop_cnt_q;

        if (phv_push) begin
            phv_wr_ptr_d = phv_wr_ptr_q + 1'b1;
        end
        if (phv_pop) begin
            phv_rd_ptr_d = phv_rd_ptr_q + 1'b1;
        end
        case ({phv_push, phv_pop})
            2'b10:   phv_count_d = phv_count_q + 1'b1;
            2'b01:   phv_count_d = phv_count_q - 1'b1;
            default: phv_count_d = phv_count_q;
        endcase

        if (vlan_push) begin
            vlan_wr_ptr_d = vlan_wr_ptr_q + 1'b1;
        end
        if (vlan_pop) begin
            vlan_rd_ptr_d = vlan_rd_ptr_q + 1'b1;
        end
        case ({vlan_push, vlan_pop})
            2'b10:   vlan_count_d = vlan_count_q + 1'b1;
            2'b01:   vlan_count_d = vlan_count_q - 1'b1;
            default: vlan_count_d = vlan_count_q;
        endcase

        if (phv_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output sequencer: VLAN first, then the matching PHV
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        vlan_pop = 1'b0;
        phv_pop  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((phv_count_q != '0) && (vlan_count_q != '0) && pipe.vlan_ready_in) begin
                    vlan_pop = 1'b1;
                    state_d  = S_SEND_PHV;
                end
            end
            S_SEND_PHV: begin
                if (pipe.stage_ready_in && (phv_count_q != '0)) begin
                    phv_pop = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q          <= S_IDLE;
            phv_wr_ptr_q     <= '0;
            phv_rd_ptr_q     <= '0;
            phv_count_q      <= '0;
            vlan_wr_ptr_q    <= '0;
            vlan_rd_ptr_q    <= '0;
            vlan_count_q     <= '0;
            drop_cnt_q       <= '0;
            phv_out_q        <= '0;
            phv_out_valid_q  <= 1'b0;
            vlan_out_q       <= '0;
            vlan_out_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            phv_wr_ptr_q     <= phv_wr_ptr_d;
            phv_rd_ptr_q     <= phv_rd_ptr_d;
            phv_count_q      <= phv_count_d;
            vlan_wr_ptr_q    <= vlan_wr_ptr_d;
            vlan_rd_ptr_q    <= vlan_rd_ptr_d;
            vlan_count_q     <= vlan_count_d;
            drop_cnt_q       <= drop_cnt_d;
            phv_out_valid_q  <= phv_pop;
            vlan_out_valid_q <= vlan_pop;
            // Data holds between pulses; only a pop reloads it from the FIFO head.
            if (phv_pop) begin
                phv_out_q <= phv_mem[phv_rd_ptr_q];
            end
            if (vlan_pop) begin
                vlan_out_q <= vlan_mem[vlan_rd_ptr_q];
            end
        end
    end

    assign pipe.phv_out        = phv_out_q;
    assign pipe.phv_out_valid  = phv_out_valid_q;
    assign pipe.vlan_out       = vlan_out_q;
    assign pipe.vlan_out_valid = vlan_out_valid_q;
    assign phv_drop_cnt        = drop_cnt_q;

    // ------------------------------------------------------------------
    // Control AXIS: one register slice, no backpressure
    // ------------------------------------------------------------------
    logic [C_S_AXIS_DATA_WIDTH-1:0]   ctl_tdata_q;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  ctl_tuser_q;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] ctl_tkeep_q;
    logic                             ctl_tvalid_q;
    logic                             ctl_tlast_q;

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            ctl_tdata_q  <= '0;
            ctl_tuser_q  <= '0;
            ctl_tkeep_q  <= '0;
            ctl_tvalid_q <= 1'b0;
            ctl_tlast_q  <= 1'b0;
        end else begin
            ctl_tdata_q  <= c_s_axis_tdata;
            ctl_tuser_q  <= c_s_axis_tuser;
            ctl_tkeep_q  <= c_s_axis_tkeep;
            ctl_tvalid_q <= c_s_axis_tvalid;
            ctl_tlast_q  <= c_s_axis_tlast;
        end
    end

    assign c_m_axis_tdata  = ctl_tdata_q;
    assign c_m_axis_tuser  = ctl_tuser_q;
    assign c_m_axis_tkeep  = ctl_tkeep_q;
    assign c_m_axis_tvalid = ctl_tvalid_q;
    assign c_m_axis_tlast  = ctl_tlast_q;
endmodule

// File: tb/tb_phv_stage_buffer.sv
// Directed bench for phv_stage_buffer: inputs driven and outputs sampled on the falling edge;
// a monitor records every valid pulse so ordering and spacing can be checked per scenario.
module tb_phv_stage_buffer;
    localparam int DW = 512;
    localparam int UW = 128;
    localparam int PL = 1024;
    localparam int VW = 12;

    logic axis_clk = 1'b0;
    logic aresetn  = 1'b0;
    logic [15:0] phv_drop_cnt;

    logic [DW-1:0]   c_s_axis_tdata;
    logic [UW-1:0]   c_s_axis_tuser;
    logic [DW/8-1:0] c_s_axis_tkeep;
    logic            c_s_axis_tvalid;
    logic            c_s_axis_tlast;
    logic [DW-1:0]   c_m_axis_tdata;
    logic [UW-1:0]   c_m_axis_tuser;
    logic [DW/8-1:0] c_m_axis_tkeep;
    logic            c_m_axis_tvalid;
    logic            c_m_axis_tlast;

    phv_stage_buffer_if #(.PHV_LEN(PL), .C_VLANID_WIDTH(VW)) bus ();

    phv_stage_buffer #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .PHV_LEN             (PL),
        .C_VLANID_WIDTH      (VW),
        .DEPTH_BITS          (3),
        .SLACK               (2)
    ) dut (
        .axis_clk       (axis_clk),
        .aresetn        (aresetn),
        .pipe           (bus.slave),
        .phv_drop_cnt   (phv_drop_cnt),
        .c_s_axis_tdata (c_s_axis_tdata),
        .c_s_axis_tuser (c_s_axis_tuser),
        .c_s_axis_tkeep (c_s_axis_tkeep),
        .c_s_axis_tvalid(c_s_axis_tvalid),
        .c_s_axis_tlast (c_s_axis_tlast),
        .c_m_axis_tdata (c_m_axis_tdata),
        .c_m_axis_tuser (c_m_axis_tuser),
        .c_m_axis_tkeep (c_m_axis_tkeep),
        .c_m_axis_tvalid(c_m_axis_tvalid),
        .c_m_axis_tlast (c_m_axis_tlast)
    );

    always #5 axis_clk = ~axis_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [PL-1:0] phv_seen  [$];
    int            phv_cyc   [$];
    logic [VW-1:0] vlan_seen [$];

    always @(posedge axis_clk) cyc <= cyc + 1;

    always @(negedge axis_clk) begin
        if (bus.phv_out_valid === 1'b1) begin
            phv_seen.push_back(bus.phv_out);
            phv_cyc.push_back(cyc);
        end
        if (bus.vlan_out_valid === 1'b1) begin
            vlan_seen.push_back(bus.vlan_out);
        end
    end

    task automatic check_eq(input string tag, input logic [PL-1:0] obs, input logic [PL-1:0] exp);
        logic [127:0] obs_lo;
        logic [127:0] exp_lo;
        checks++;
        if (obs !== exp) begin
            failures++;
            obs_lo = obs[127:0];
            exp_lo = exp[127:0];
            $display("FAIL %s got=0x%0h want=0x%0h (low 128b)", tag, obs_lo, exp_lo);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs[63:0]);
        end
    endtask

    function automatic logic [PL-1:0] phv_pat(input int i);
        logic [63:0] w;
        w = 64'hA5A5_0000_0000_0000 | 64'(i);
        return {16{w}};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge axis_clk);
    endtask

    task automatic clear_seen();
        phv_seen.delete();
        phv_cyc.delete();
        vlan_seen.delete();
    endtask

    function automatic logic [PL-1:0] phv_at(input int k);
        return (k < phv_seen.size()) ? phv_seen[k] : '0;
    endfunction

    function automatic logic [VW-1:0] vlan_at(input int k);
        return (k < vlan_seen.size()) ? vlan_seen[k] : '0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PL-1:0] pat_a;
        pat_a = {16{64'hDEAD_BEEF_0000_0001}};

        bus.phv_in         = '0;
        bus.phv_in_valid   = 1'b0;
        bus.vlan_in        = '0;
        bus.vlan_valid_in  = 1'b0;
        bus.stage_ready_in = 1'b1;
        bus.vlan_ready_in  = 1'b1;
        c_s_axis_tdata     = '0;
        c_s_axis_tuser     = '0;
        c_s_axis_tkeep     = '0;
        c_s_axis_tvalid    = 1'b0;
        c_s_axis_tlast     = 1'b0;

        step(3);
        aresetn = 1'b1;
        step(1);

        // ---- reset state
        check_eq("rst_stage_ready_out", PL'(bus.stage_ready_out), PL'(1));
        check_eq("rst_vlan_ready_out",  PL'(bus.vlan_ready_out),  PL'(1));
        check_eq("rst_phv_out_valid",   PL'(bus.phv_out_valid),   PL'(0));
        check_eq("rst_vlan_out_valid",  PL'(bus.vlan_out_valid),  PL'(0));
        check_eq("rst_phv_out",         bus.phv_out,              PL'(0));
        check_eq("rst_vlan_out",        PL'(bus.vlan_out),        PL'(0));
        check_eq("rst_drop_cnt",        PL'(phv_drop_cnt),        PL'(0));
        check_eq("rst_c_m_tvalid",      PL'(c_m_axis_tvalid),     PL'(0));

        // ---- single pair: captured at edge 0, VLAN visible after edge 1, PHV after edge 2
        bus.phv_in = pat_a; bus.phv_in_valid = 1'b1;
        bus.vlan_in = 12'h005; bus.vlan_valid_in = 1'b1;
        step(1);
        bus.phv_in_valid = 1'b0; bus.vlan_valid_in = 1'b0;
        check_eq("pair_e0_vlan_valid", PL'(bus.vlan_out_valid), PL'(0));
        step(1);
        check_eq("pair_e1_vlan_valid", PL'(bus.vlan_out_valid), PL'(1));
        check_eq("pair_e1_vlan_out",   PL'(bus.vlan_out),       PL'(12'h005));
        check_eq("pair_e1_phv_valid",  PL'(bus.phv_out_valid),  PL'(0));
        step(1);
        check_eq("pair_e2_phv_valid",  PL'(bus.phv_out_valid),  PL'(1));
        check_eq("pair_e2_phv_out",    bus.phv_out,             pat_a);
        check_eq("pair_e2_vlan_valid", PL'(bus.vlan_out_valid), PL'(0));
        step(3);
        check_eq("pair_idle_phv_valid", PL'(bus.phv_out_valid), PL'(0));
        check_eq("pair_hold_phv_out",   bus.phv_out,            pat_a);
        check_eq("pair_hold_vlan_out",  PL'(bus.vlan_out),      PL'(12'h005));

        // ---- control path
        check_eq("ctl_before_tvalid", PL'(c_m_axis_tvalid), PL'(0));
        c_s_axis_tdata = DW'(16'h1234); c_s_axis_tlast = 1'b1; c_s_axis_tvalid = 1'b1;
        c_s_axis_tkeep = '1; c_s_axis_tuser = UW'(8'h5A);
        clear_seen();
        step(1);
        c_s_axis_tvalid = 1'b0; c_s_axis_tlast = 1'b0; c_s_axis_tdata = '0;
        c_s_axis_tkeep = '0; c_s_axis_tuser = '0;
        check_eq("ctl_tvalid", PL'(c_m_axis_tvalid), PL'(1));
        check_eq("ctl_tdata",  PL'(c_m_axis_tdata),  PL'(16'h1234));
        check_eq("ctl_tlast",  PL'(c_m_axis_tlast),  PL'(1));
        check_eq("ctl_tkeep",  PL'(c_m_axis_tkeep),  {{(PL-DW/8){1'b0}}, {(DW/8){1'b1}}});
        check_eq("ctl_tuser",  PL'(c_m_axis_tuser),  PL'(8'h5A));
        step(1);
        check_eq("ctl_after_tvalid", PL'(c_m_axis_tvalid), PL'(0));
        check_eq("ctl_no_phv_pulse", PL'(phv_seen.size() + vlan_seen.size()), PL'(0));

        // ---- stage backpressure: 8 pairs held, ready falls at count 6
        clear_seen();
        bus.stage_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.phv_in = phv_pat(i); bus.phv_in_valid = 1'b1;
            bus.vlan_in = VW'(12'h100 + i); bus.vlan_valid_in = 1'b1;
            step(1);
            check_eq($sformatf("bp_stage_ready_cnt%0d", i + 1), PL'(bus.stage_ready_out),
                     PL'((i + 1) < 6 ? 1 : 0));
        end
        bus.phv_in_valid = 1'b0; bus.vlan_valid_in = 1'b0;
        step(4);
        check_eq("bp_held_phv_count",  PL'(phv_seen.size()),  PL'(0));
        check_eq("bp_held_vlan_count", PL'(vlan_seen.size()), PL'(1));
        bus.stage_ready_in = 1'b1;
        step(24);
        check_eq("bp_phv_total",  PL'(phv_seen.size()),  PL'(8));
        check_eq("bp_vlan_total", PL'(vlan_seen.size()), PL'(8));
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("bp_phv%0d", k),  phv_at(k),      phv_pat(k));
            check_eq($sformatf("bp_vlan%0d", k), PL'(vlan_at(k)), PL'(12'h100 + k));
        end
        for (int k = 1; k < 8; k++) begin
            check_eq($sformatf("bp_gap%0d", k),
                     PL'((k < phv_cyc.size()) ? (phv_cyc[k] - phv_cyc[k-1]) : 0), PL'(2));
        end
        check_eq("bp_ready_back", PL'(bus.stage_ready_out), PL'(1));

        // ---- overflow: 10 PHVs into an undrained buffer
        clear_seen();
        bus.stage_ready_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.phv_in = phv_pat(20 + i); bus.phv_in_valid = 1'b1;
            bus.vlan_in = VW'(12'h200 + i); bus.vlan_valid_in = (i < 8);
            step(1);
        end
        bus.phv_in_valid = 1'b0; bus.vlan_valid_in = 1'b0;
        step(1);
        check_eq("ovf_drop_cnt",    PL'(phv_drop_cnt),        PL'(2));
        check_eq("ovf_stage_ready", PL'(bus.stage_ready_out), PL'(0));
        bus.stage_ready_in = 1'b1;
        step(24);
        check_eq("ovf_phv_total", PL'(phv_seen.size()), PL'(8));
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("ovf_phv%0d", k),  phv_at(k),      phv_pat(20 + k));
            check_eq($sformatf("ovf_vlan%0d", k), PL'(vlan_at(k)), PL'(12'h200 + k));
        end

        // ---- VLAN port held off by the stage
        clear_seen();
        bus.vlan_ready_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.phv_in = phv_pat(40 + i); bus.phv_in_valid = 1'b1;
            bus.vlan_in = VW'(12'h300 + i); bus.vlan_valid_in = 1'b1;
            step(1);
        end
        bus.phv_in_valid = 1'b0; bus.vlan_valid_in = 1'b0;
        step(6);
        check_eq("hold_no_vlan", PL'(vlan_seen.size()), PL'(0));
        check_eq("hold_no_phv",  PL'(phv_seen.size()),  PL'(0));
        bus.vlan_ready_in = 1'b1;
        step(1);
        check_eq("hold_resume_vlan_valid", PL'(bus.vlan_out_valid), PL'(1));
        check_eq("hold_resume_vlan_out",   PL'(bus.vlan_out),       PL'(12'h300));
        check_eq("hold_resume_phv_valid",  PL'(bus.phv_out_valid),  PL'(0));
        step(1);
        check_eq("hold_resume_phv_valid2", PL'(bus.phv_out_valid),  PL'(1));
        check_eq("hold_resume_phv_out",    bus.phv_out,             phv_pat(40));
        step(6);
        check_eq("hold_phv_total", PL'(phv_seen.size()), PL'(2));
        check_eq("hold_phv1",      phv_at(1),            phv_pat(41));

        // ---- reset while waiting in SEND_PHV with 3 entries queued
        bus.stage_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.phv_in = phv_pat(60 + i); bus.phv_in_valid = 1'b1;
            bus.vlan_in = VW'(12'h400 + i); bus.vlan_valid_in = 1'b1;
            step(1);
        end
        bus.phv_in_valid = 1'b0; bus.vlan_valid_in = 1'b0;
        step(3);
        check_eq("mrst_pre_drop_cnt", PL'(phv_drop_cnt), PL'(2));
        clear_seen();
        aresetn = 1'b0;
        bus.stage_ready_in = 1'b1;
        step(2);
        check_eq("mrst_in_reset_phv_valid", PL'(bus.phv_out_valid), PL'(0));
        aresetn = 1'b1;
        step(8);
        check_eq("mrst_no_pulses",   PL'(phv_seen.size() + vlan_seen.size()), PL'(0));
        check_eq("mrst_drop_cnt",    PL'(phv_drop_cnt),         PL'(0));
        check_eq("mrst_stage_ready", PL'(bus.stage_ready_out),  PL'(1));
        check_eq("mrst_vlan_ready",  PL'(bus.vlan_ready_out),   PL'(1));
        bus.phv_in = phv_pat(70); bus.phv_in_valid = 1'b1;
        bus.vlan_in = 12'h470; bus.vlan_valid_in = 1'b1;
        step(1);
        bus.phv_in_valid = 1'b0; bus.vlan_valid_in = 1'b0;
        step(6);
        check_eq("mrst_after_phv_total", PL'(phv_seen.size()), PL'(1));
        check_eq("mrst_after_phv",       phv_at(0),            phv_pat(70));
        check_eq("mrst_after_vlan",      PL'(vlan_at(0)),      PL'(12'h470));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
